// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC-format SPI frame receiver: command codes,
// receiver FSM states and the default frame geometry.
package dac_spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 24;
  localparam int DATA_W_DEFAULT     = 12;

  localparam logic [3:0] CMD_NOP          = 4'h0;
  localparam logic [3:0] CMD_WRITE_INPUT  = 4'h1;
  localparam logic [3:0] CMD_UPDATE_DAC   = 4'h2;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] CMD_CTRL         = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/dac_spi_frame_receiver_sync_edge.sv
// Brings one asynchronous SPI line into the system clock domain and reports
// its synchronized level plus single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Flops reset high so an idle-high SPI line produces no edge out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/dac_spi_frame_receiver.sv
// SPI responder for 24-bit DAC write frames: oversamples SYNCn/SCL/SDA with
// SYS_CLK and hands each complete frame out on a valid/ready interface.
module dac_spi_frame_receiver
  import dac_spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              SYS_CLK,
  input  logic              RSTn,
  input  logic              SPI_SYNCn,
  input  logic              SPI_SCL,
  input  logic              SPI_SDA,
  output logic [3:0]        OUT_CMD,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              FRAME_ERR,
  output logic              OVERRUN
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic syncnLevel, syncnRise, syncnFall;
  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_syncn (
    .clk_i(SYS_CLK), .rst_ni(RSTn), .async_i(SPI_SYNCn),
    .level_o(syncnLevel), .rise_o(syncnRise), .fall_o(syncnFall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk_i(SYS_CLK), .rst_ni(RSTn), .async_i(SPI_SCL),
    .level_o(sclLevel), .rise_o(sclRise), .fall_o(sclFall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk_i(SYS_CLK), .rst_ni(RSTn), .async_i(SPI_SDA),
    .level_o(sdaLevel), .rise_o(sdaRise), .fall_o(sdaFall)
  );

  assign unused_edges = ^{sclLevel, sclRise, sdaRise, sdaFall};

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bitCount_q, bitCount_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frameErr_q, frameErr_d;
  logic                   overrun_q, overrun_d;
  logic [SYNC_STAGES-1:0] warm_q;
  logic                   armed_q, armed_d;

  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      bitCount_q <= '0;
      shift_q    <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      warm_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCount_q <= bitCount_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
      warm_q     <= {warm_q[SYNC_STAGES-2:0], 1'b1};
      armed_q    <= armed_d;
    end
  end

  // A frame may only start once SYNCn has been seen high with a synchronizer
  // chain refilled after reset, so a frame already running at reset release
  // is ignored until its SYNCn rises.
  always_comb begin
    state_d    = state_q;
    bitCount_d = bitCount_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    valid_d    = valid_q;
    frameErr_d = 1'b0;
    overrun_d  = 1'b0;
    armed_d    = armed_q | (warm_q[SYNC_STAGES-1] & syncnLevel);

    if (valid_q && OUT_READY) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (syncnFall && armed_q) begin
          state_d    = ST_SHIFT;
          bitCount_d = '0;
          shift_d    = '0;
        end
      end
      ST_SHIFT: begin
        if (sclFall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdaLevel};
          if (bitCount_q != CNT_SAT) begin
            bitCount_d = bitCount_q + CNT_W'(1);
          end
        end
        if (syncnRise) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (bitCount_q == CNT_FULL) begin
          if (!valid_q || OUT_READY) begin
            cmd_d   = shift_q[FRAME_BITS-1 -: 4];
            data_d  = shift_q[FRAME_BITS-5 -: DATA_W];
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frameErr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign OUT_CMD   = cmd_q;
  assign OUT_DATA  = data_q;
  assign OUT_VALID = valid_q;
  assign FRAME_ERR = frameErr_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_dac_spi_frame_receiver.sv
// Self-checking bench for dac_spi_frame_receiver: frame vectors from a table,
// a word scoreboard fed at stimulus time, and hand-written corner sequences.
module tb_dac_spi_frame_receiver;
  import dac_spi_pkg::*;

  logic        SYS_CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        SPI_SYNCn = 1'b1;
  logic        SPI_SCL = 1'b1;
  logic        SPI_SDA = 1'b0;
  logic        OUT_READY = 1'b1;
  logic [3:0]  OUT_CMD;
  logic [11:0] OUT_DATA;
  logic        OUT_VALID;
  logic        FRAME_ERR;
  logic        OVERRUN;

  dac_spi_frame_receiver dut (
    .SYS_CLK(SYS_CLK), .RSTn(RSTn),
    .SPI_SYNCn(SPI_SYNCn), .SPI_SCL(SPI_SCL), .SPI_SDA(SPI_SDA),
    .OUT_CMD(OUT_CMD), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  always #10 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    bit          good;
    logic [3:0]  cmd;
    logic [11:0] data;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          errPulses = 0;
  int          ovrPulses = 0;
  int          accepts = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and compares every accepted word with the scoreboard.
  always @(negedge SYS_CLK) begin
    if (FRAME_ERR) errPulses++;
    if (OVERRUN) ovrPulses++;
    if (OUT_VALID && OUT_READY) begin
      accepts++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected got %0h_%0h expected none", OUT_CMD, OUT_DATA);
      end else begin
        checkOutput("sb_word", {16'h0, OUT_CMD, OUT_DATA}, {16'h0, expQ.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  task automatic shiftBits(input logic [31:0] word, input int nbits);
    SPI_SYNCn = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      SPI_SDA = word[nbits-1-i];
      tick(5);
      SPI_SCL = 1'b0;
      tick(5);
      SPI_SCL = 1'b1;
    end
    tick(3);
  endtask

  task automatic applyStimulus(input logic [31:0] word, input int nbits);
    shiftBits(word, nbits);
    SPI_SYNCn = 1'b1;
    tick(8);
  endtask

  initial begin
    int e0, a0, o0, lat;
    logic [15:0] seenWord;

    vecs[0] = '{32'h25A500,   24, 1'b1, 4'h2, 12'h5A5};
    vecs[1] = '{32'h3ABC0,    20, 1'b0, 4'h0, 12'h000};
    vecs[2] = '{32'h2AAAAAA,  26, 1'b0, 4'h0, 12'h000};
    vecs[3] = '{32'h000000,   24, 1'b1, 4'h0, 12'h000};
    vecs[4] = '{32'hFFFFFF,   24, 1'b1, 4'hF, 12'hFFF};
    vecs[5] = '{32'h1,         1, 1'b0, 4'h0, 12'h000};
    vecs[6] = '{32'h1C3C3C3,  25, 1'b0, 4'h0, 12'h000};
    vecs[7] = '{32'h4123FF,   24, 1'b1, 4'h4, 12'h123};

    tick(2);
    checkOutput("rst_valid", {31'h0, OUT_VALID}, 32'h0);
    checkOutput("rst_cmd", {28'h0, OUT_CMD}, 32'h0);
    checkOutput("rst_data", {20'h0, OUT_DATA}, 32'h0);
    checkOutput("rst_ferr", {31'h0, FRAME_ERR}, 32'h0);
    checkOutput("rst_ovr", {31'h0, OVERRUN}, 32'h0);
    RSTn = 1'b1;
    tick(5);

    // First frame: latency from the first edge sampling SYNCn high.
    e0 = errPulses; a0 = accepts; o0 = ovrPulses;
    expQ.push_back({CMD_WRITE_UPDATE, 12'hABC});
    shiftBits(32'h3ABC00, 24);
    SPI_SYNCn = 1'b1;
    lat = 0;
    seenWord = '0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick(1);
      if (OUT_VALID) begin
        lat = c;
        seenWord = {OUT_CMD, OUT_DATA};
      end
    end
    checkOutput("first_latency", lat, 4);
    checkOutput("first_word", {16'h0, seenWord}, {16'h0, CMD_WRITE_UPDATE, 12'hABC});
    tick(1);
    checkOutput("first_valid_one_cycle", {31'h0, OUT_VALID}, 32'h0);
    tick(4);
    checkOutput("first_accepts", accepts - a0, 1);
    checkOutput("first_no_ferr", errPulses - e0, 0);
    checkOutput("first_no_ovr", ovrPulses - o0, 0);

    for (int v = 0; v < 8; v++) begin
      e0 = errPulses; a0 = accepts;
      if (vecs[v].good) expQ.push_back({vecs[v].cmd, vecs[v].data});
      applyStimulus(vecs[v].word, vecs[v].nbits);
      checkOutput($sformatf("vec%0d_ferr", v), errPulses - e0, vecs[v].good ? 0 : 1);
      checkOutput($sformatf("vec%0d_accepts", v), accepts - a0, vecs[v].good ? 1 : 0);
    end

    // Overrun: second good frame arrives while the first is still held.
    OUT_READY = 1'b0;
    e0 = errPulses; a0 = accepts; o0 = ovrPulses;
    expQ.push_back({CMD_WRITE_INPUT, 12'h001});
    applyStimulus(32'h100100, 24);
    checkOutput("ovr_held_valid", {31'h0, OUT_VALID}, 32'h1);
    applyStimulus(32'h200200, 24);
    checkOutput("ovr_pulse", ovrPulses - o0, 1);
    checkOutput("ovr_no_ferr", errPulses - e0, 0);
    checkOutput("ovr_word_kept", {16'h0, OUT_CMD, OUT_DATA}, {16'h0, CMD_WRITE_INPUT, 12'h001});
    OUT_READY = 1'b1;
    tick(2);
    checkOutput("ovr_accepts", accepts - a0, 1);
    checkOutput("ovr_valid_clear", {31'h0, OUT_VALID}, 32'h0);

    // Load and accept in the same cycle.
    OUT_READY = 1'b0;
    expQ.push_back({CMD_WRITE_UPDATE, 12'h111});
    applyStimulus(32'h311100, 24);
    a0 = accepts; o0 = ovrPulses;
    expQ.push_back({CMD_UPDATE_DAC, 12'h222});
    shiftBits(32'h222200, 24);
    SPI_SYNCn = 1'b1;
    tick(3);
    OUT_READY = 1'b1;
    tick(1);
    OUT_READY = 1'b0;
    checkOutput("same_valid", {31'h0, OUT_VALID}, 32'h1);
    checkOutput("same_word", {16'h0, OUT_CMD, OUT_DATA}, {16'h0, CMD_UPDATE_DAC, 12'h222});
    checkOutput("same_no_ovr", ovrPulses - o0, 0);
    checkOutput("same_accepts", accepts - a0, 1);
    tick(6);
    OUT_READY = 1'b1;
    tick(2);
    checkOutput("same_accepts2", accepts - a0, 2);
    checkOutput("same_valid_clear", {31'h0, OUT_VALID}, 32'h0);

    // Reset mid-frame, released with SYNCn still low.
    e0 = errPulses; a0 = accepts;
    shiftBits(32'h3FF, 10);
    RSTn = 1'b0;
    tick(2);
    RSTn = 1'b1;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      SPI_SDA = i[0];
      tick(5);
      SPI_SCL = 1'b0;
      tick(5);
      SPI_SCL = 1'b1;
    end
    tick(3);
    SPI_SYNCn = 1'b1;
    tick(8);
    checkOutput("rstmid_no_ferr", errPulses - e0, 0);
    checkOutput("rstmid_no_output", accepts - a0, 0);
    expQ.push_back({CMD_CTRL, 12'hFFF});
    applyStimulus(32'h4FFF00, 24);
    checkOutput("rstmid_clean_accepts", accepts - a0, 1);
    checkOutput("rstmid_clean_no_ferr", errPulses - e0, 0);

    // SCL activity and sub-cycle glitches while SYNCn is high.
    e0 = errPulses; a0 = accepts; o0 = ovrPulses;
    for (int i = 0; i < 8; i++) begin
      SPI_SCL = 1'b0;
      tick(3);
      SPI_SDA = i[0];
      SPI_SCL = 1'b1;
      tick(3);
      SPI_SCL = 1'b0;
      #4;
      SPI_SCL = 1'b1;
      #4;
    end
    tick(8);
    checkOutput("glitch_no_ferr", errPulses - e0, 0);
    checkOutput("glitch_no_output", accepts - a0, 0);
    checkOutput("glitch_no_ovr", ovrPulses - o0, 0);
    checkOutput("glitch_valid_low", {31'h0, OUT_VALID}, 32'h0);

    checkOutput("sb_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_frame_receiver.md
# dac_spi_frame_receiver

- SPI responder (slave) for the AD5681R-format 24-bit DAC write protocol: decodes SYNCn/SCL/SDA frames driven into the FPGA and presents each command/data word on a valid/ready handshake.
- Sits on the edge-connector/header side of the MAX 10 design, opposite the on-board DAC SPI master. Used for board-to-board links and for loopback checking of the DAC driver.
- Oversamples the SPI lines with SYS_CLK; the SPI lines carry no clock domain of their own.

## Interface
- FRAME_BITS, 24, bits per valid frame, MSB first.
- DATA_W, 12, data field width; taken from frame bits [19 : 20-DATA_W].
- SYNC_STAGES, 2, synchronizer flops per SPI input (≥2).

- SYS_CLK  in  1  50 MHz system clock; the only clock.
- RSTn  in  1  reset, asynchronous assert, active-low.
- SPI_SYNCn  in  1  frame select, active-low, asynchronous.
- SPI_SCL  in  1  serial clock, asynchronous; data sampled on falling edge.
- SPI_SDA  in  1  serial data, asynchronous.
- OUT_CMD  out  4  frame bits [23:20].
- OUT_DATA  out  DATA_W  data field.
- OUT_VALID  out  1  word held; cleared on OUT_VALID & OUT_READY.
- OUT_READY  in  1  consumer accepts the held word.
- FRAME_ERR  out  1  one-cycle pulse: frame ended with bit count ≠ FRAME_BITS.
- OVERRUN  out  1  one-cycle pulse: good frame dropped because OUT_VALID was still high.

## Operation
- Synchronization:
  - Each SPI input passes through SYNC_STAGES flops, then one history flop for edge detect.
  - SPI_SYNCn and SPI_SCL are double-registered to sys domain before any decision.
- FSM states and transitions:
  - IDLE → SHIFT on synchronized SYNCn falling; this clears the bit counter and shift register.
  - SHIFT: each synchronized SCL falling edge shifts SDA into the LSB of a FRAME_BITS shift register. The bit counter increments and saturates at FRAME_BITS+1.
  - SHIFT → CHECK on synchronized SYNCn rising.
  - CHECK → IDLE unconditionally after one cycle:
    - count == FRAME_BITS and OUT_VALID low (or being accepted this cycle): load OUT_CMD/OUT_DATA, set OUT_VALID.
    - count == FRAME_BITS and OUT_VALID held: pulse OVERRUN; the held word is kept.
    - count ≠ FRAME_BITS (short or long frame): pulse FRAME_ERR; no load.
- SCL falling edges while in IDLE or CHECK are ignored.
- Handshake: OUT_CMD/OUT_DATA stay stable while OUT_VALID is high. A load and an accept in the same cycle results in the new word valid.
- Reset mid-frame: all state is cleared immediately and the partial frame is discarded. If SYNCn is already low when RSTn releases, the block waits for a SYNCn rising then falling edge before accepting a frame.

## Timing
- Reset values: OUT_CMD=0, OUT_DATA=0, OUT_VALID=0, FRAME_ERR=0, OVERRUN=0, FSM=IDLE, synchronizers=1 (SYNCn/SCL idle high).
- SCL high and low phases must each be ≥ 3 SYS_CLK periods (SCL ≤ 8 MHz at 50 MHz).
- SDA must be stable ≥ 3 SYS_CLK periods around SCL falling.
- SYNCn high time between frames must be ≥ 4 SYS_CLK periods.
- Latency: OUT_VALID/FRAME_ERR/OVERRUN rise SYNC_STAGES+2 SYS_CLK edges after the first edge that samples SPI_SYNCn high (4 edges at default).
- Throughput: one word per frame; back-to-back frames are lossless if OUT_READY returns before the next SYNCn rising.

## Structure
- Shared package (dac_spi_pkg):
  - command code constants: NOP=4'h0, WRITE_INPUT=4'h1, UPDATE_DAC=4'h2, WRITE_UPDATE=4'h3, CTRL=4'h4;
  - FSM state enum;
  - default FRAME_BITS.
- One sub-module: spi_sync_edge (parameterized SYNC_STAGES), one instance per SPI input, outputting the synchronized level plus rise/fall strobes.

## Test plan
- Reset, then frame 0x3ABC00 at SCL = 5 MHz with OUT_READY=1 → OUT_VALID for one cycle, OUT_CMD=4'h3, OUT_DATA=12'hABC, arriving 4 cycles after SYNCn high; no error pulses.
- 20-bit frame (SYNCn raised early) → one FRAME_ERR pulse, OUT_VALID stays 0. 26-bit frame → one FRAME_ERR pulse.
- OUT_READY=0, send frames 0x100100 then 0x200200 → first word (cmd 1, data 12'h001) held; OVERRUN pulses once; after OUT_READY=1, the same first word is accepted.
- Frame completes in the same cycle OUT_READY accepts the prior word → new word loads, OUT_VALID stays high, no OVERRUN.
- RSTn asserted after 10 bits of a frame, released with SYNCn still low, then clean frame 0x4FFF00 → nothing is output for the aborted frame; the clean frame yields cmd 4, data 12'hFFF.
- SCL toggling with SYNCn high, with glitches shorter than 1 SYS_CLK → no output, no error pulses.
